mux_21_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one W-bit 2:1 mux datapath between two requesters.

---
 rtl/mux_arb_pkg.sv | 16 +
 rtl/mux_21_w.sv | 13 +
 rtl/mux_21_rr_arbiter.sv | 116 +++++++++++
 tb/tb_mux_21_rr_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the two-source round-robin mux arbiter.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        G0,
        G1
    } state_t;

    localparam int IDX_W = 1;

    function automatic logic [1:0] onehot2(input logic [IDX_W-1:0] idx);
        return idx[0] ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mux_21_w.sv
// Combinational W-bit 2:1 mux shared by both requesters.
module mux_21_w #(
    parameter int W = 8
) (
    input  logic         s,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    output logic [W-1:0] y
);

    assign y = s ? d1 : d0;

endmodule

// File: rtl/mux_21_rr_arbiter.sv
// Round-robin arbiter driving a registered 2:1 mux datapath.
// Optional burst limit enabled by defining ARB_TIMEOUT_EN.
module mux_21_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int W        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    output logic [1:0]   gnt,
    output logic         s,
    output logic [W-1:0] y,
    output logic         y_vld
);

    state_t       state;
    state_t       nxt;
    logic         last;
    logic         hold_hit;
    logic         smp;
    logic [W-1:0] mux_y;

    mux_21_w #(.W(W)) u_mux (
        .s  (s),
        .d0 (d0),
        .d1 (d1),
        .y  (mux_y)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);

    logic [CW-1:0] hold_cnt;

    assign hold_hit = (hold_cnt == CW'(MAX_HOLD));

    // Count starts at 1 on the first granted cycle and saturates at MAX_HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (nxt == IDLE) begin
            hold_cnt <= '0;
        end else if (nxt != state) begin
            hold_cnt <= CW'(1);
        end else if (!hold_hit) begin
            hold_cnt <= hold_cnt + CW'(1);
        end
    end
`else
    logic unused_hold;

    assign unused_hold = (MAX_HOLD != 0);
    assign hold_hit    = 1'b0;
`endif

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                unique case (req)
                    2'b01:   nxt = G0;
                    2'b10:   nxt = G1;
                    2'b11:   nxt = last ? G0 : G1;
                    default: nxt = IDLE;
                endcase
            end
            G0: begin
                if (req[0] && !(hold_hit && req[1])) nxt = G0;
                else if (req[1])                     nxt = G1;
                else                                 nxt = IDLE;
            end
            G1: begin
                if (req[1] && !(hold_hit && req[0])) nxt = G1;
                else if (req[0])                     nxt = G0;
                else                                 nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= 2'b00;
            s     <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= nxt;
            if (nxt == IDLE) begin
                gnt <= 2'b00;
            end else begin
                gnt  <= onehot2(nxt == G1);
                s    <= (nxt == G1);
                last <= (nxt == G1);
            end
        end
    end

    // Data is only taken while the granted source is still requesting.
    assign smp = (gnt[0] & req[0]) | (gnt[1] & req[1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            y     <= '0;
            y_vld <= 1'b0;
        end else begin
            y_vld <= smp;
            if (smp) y <= mux_y;
        end
    end

endmodule

// File: tb/tb_mux_21_rr_arbiter.sv
// Directed scoreboard bench for mux_21_rr_arbiter.
module tb_mux_21_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [7:0] d0  = 8'h00;
    logic [7:0] d1  = 8'h00;
    logic [1:0] gnt;
    logic       s;
    logic [7:0] y;
    logic       y_vld;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    mux_21_rr_arbiter #(.W(8), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .d0    (d0),
        .d1    (d1),
        .gnt   (gnt),
        .s     (s),
        .y     (y),
        .y_vld (y_vld)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (y_vld) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL y_unexpected: got y=%h with y_vld=1, expected no output", y);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (y !== e) begin
                    bad++;
                    $display("FAIL y_data: got %h expected %h", y, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Apply one cycle of inputs; smp marks an edge that must sample ey.
    task automatic step(input logic [1:0] r, input logic [7:0] a, input logic [7:0] b,
                        input bit smp, input logic [7:0] ey, input logic [1:0] eg,
                        input string nm);
        req = r;
        d0  = a;
        d1  = b;
        if (smp) exp_q.push_back(ey);
        @(posedge clk);
        #1;
        chk({nm, "_gnt"}, {6'd0, gnt}, {6'd0, eg});
        if (eg != 2'b00) chk({nm, "_s"}, {7'd0, s}, {7'd0, eg[1]});
    endtask

    initial begin
        // 1: reset, then tie goes to source 0
        rst = 1'b1;
        step(2'b00, 8'h00, 8'h00, 0, 8'h00, 2'b00, "rst_a");
        step(2'b00, 8'h00, 8'h00, 0, 8'h00, 2'b00, "rst_b");
        chk("rst_s", {7'd0, s}, 8'h00);
        chk("rst_y", y, 8'h00);
        chk("rst_vld", {7'd0, y_vld}, 8'h00);
        rst = 1'b0;
        step(2'b11, 8'h11, 8'h22, 0, 8'h00, 2'b01, "t1_first");
        step(2'b11, 8'h11, 8'h22, 1, 8'h11, 2'b01, "t1_hold");
        step(2'b00, 8'h11, 8'h22, 0, 8'h00, 2'b00, "t1_idle");

        // 2: five-cycle burst from source 0
        step(2'b01, 8'hA5, 8'h00, 0, 8'h00, 2'b01, "t2_gnt");
        for (int i = 0; i < 5; i++)
            step(2'b01, 8'hA5, 8'h00, 1, 8'hA5, 2'b01, "t2_burst");
        step(2'b00, 8'hA5, 8'h00, 0, 8'h00, 2'b00, "t2_idle");

        // 3: direct handover 0 -> 1
        step(2'b01, 8'h5A, 8'h3C, 0, 8'h00, 2'b01, "t3_gnt0");
        step(2'b11, 8'h5A, 8'h3C, 1, 8'h5A, 2'b01, "t3_both");
        step(2'b10, 8'h5A, 8'h3C, 0, 8'h00, 2'b10, "t3_switch");
        step(2'b10, 8'h5A, 8'h3C, 1, 8'h3C, 2'b10, "t3_d1");
        step(2'b00, 8'h5A, 8'h3C, 0, 8'h00, 2'b00, "t3_idle");

        // 4: alternating back-to-back bursts
        step(2'b11, 8'h01, 8'h02, 0, 8'h00, 2'b01, "t4_a");
        step(2'b11, 8'h01, 8'h02, 1, 8'h01, 2'b01, "t4_b");
        step(2'b11, 8'h03, 8'h02, 1, 8'h03, 2'b01, "t4_c");
        step(2'b10, 8'h03, 8'h04, 0, 8'h00, 2'b10, "t4_d");
        step(2'b11, 8'h03, 8'h04, 1, 8'h04, 2'b10, "t4_e");
        step(2'b11, 8'h03, 8'h06, 1, 8'h06, 2'b10, "t4_f");
        step(2'b01, 8'h07, 8'h06, 0, 8'h00, 2'b01, "t4_g");
        step(2'b11, 8'h07, 8'h06, 1, 8'h07, 2'b01, "t4_h");
        step(2'b11, 8'h08, 8'h06, 1, 8'h08, 2'b01, "t4_i");
        step(2'b10, 8'h08, 8'h09, 0, 8'h00, 2'b10, "t4_j");
        step(2'b10, 8'h08, 8'h09, 1, 8'h09, 2'b10, "t4_k");
        step(2'b00, 8'h08, 8'h09, 0, 8'h00, 2'b00, "t4_idle");

        // 5: reset in the middle of a source-1 burst
        step(2'b10, 8'h66, 8'h77, 0, 8'h00, 2'b10, "t5_gnt1");
        step(2'b10, 8'h66, 8'h77, 1, 8'h77, 2'b10, "t5_burst");
        rst = 1'b1;
        step(2'b10, 8'h66, 8'h77, 0, 8'h00, 2'b00, "t5_rst");
        chk("t5_vld", {7'd0, y_vld}, 8'h00);
        chk("t5_y", y, 8'h00);
        rst = 1'b0;
        step(2'b11, 8'h66, 8'h77, 0, 8'h00, 2'b01, "t5_tie");
        step(2'b00, 8'h66, 8'h77, 0, 8'h00, 2'b00, "t5_idle");

        // 6: constant contention
        rst = 1'b1;
        step(2'b00, 8'h00, 8'h00, 0, 8'h00, 2'b00, "t6_rst");
        rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
`ifdef ARB_TIMEOUT_EN
            step(2'b11, 8'hAA, 8'hBB, k >= 2, (k <= 5) ? 8'hAA : 8'hBB,
                 (k >= 5 && k <= 8) ? 2'b10 : 2'b01, "t6_to");
`else
            step(2'b11, 8'hAA, 8'hBB, k >= 2, 8'hAA, 2'b01, "t6_hold");
`endif
        end
        step(2'b00, 8'hAA, 8'hBB, 0, 8'h00, 2'b00, "t6_idle");

        repeat (3) @(negedge clk);
        chk("drain", 8'(exp_q.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
